// File: rtl/hyper_read_packer_if.sv
// Halfword-in / packed-word-out stream bundle of the HyperBus read packer.
// The slave modport is the packer's view; the master modport is the FIFO/consumer side.
interface hyper_read_packer_if;
    logic        in_valid_i;
    logic [15:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_strb_o;
    logic        out_last_o;
    logic        out_ready_i;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_strb_o,
        output out_last_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_strb_o,
        input  out_last_o
    );
endinterface

// File: rtl/hyper_read_packer.sv
// Packs the HyperBus read halfword stream into 32-bit words with byte strobes and a last flag.
// Optional inactivity abort is built when HYPER_READ_TIMEOUT_EN is defined.
module hyper_read_packer #(
    parameter int CNT_W = 16,
    parameter int TO_W  = 16
) (
    input  logic                 clk0,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     len_i,
    input  logic                 half_offset_i,
    input  logic [TO_W-1:0]      cfg_timeout_i,
    hyper_read_packer_if.slave   bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  rem_q;
    logic              pos_q;
    logic              loVld_q;
    logic [15:0]       accLo_q;
    logic              outValid_q;
    logic [31:0]       outData_q;
    logic [3:0]        outStrb_q;
    logic              outLast_q;
    logic              done_q;

    logic              outFree;
    logic              inReady;
    logic              accept;
    logic              emitValid_d;
    logic [31:0]       emitData_d;
    logic [3:0]        emitStrb_d;
    logic              emitLast_d;

`ifdef HYPER_READ_TIMEOUT_EN
    logic [TO_W-1:0]   idleCnt_q;
    logic              timeout_q;
    logic              abort_d;
`else
    logic              unusedCfg;
    assign unusedCfg = ^cfg_timeout_i;
`endif

    // The output register may be reloaded on the same edge its word is taken.
    assign outFree = !outValid_q || bus.out_ready_i;

    always_comb begin
        inReady = 1'b0;
        case (state_q)
            IDLE:    inReady = 1'b1;
            COLLECT: inReady = outFree;
            default: inReady = 1'b0;
        endcase
    end

    assign accept = (state_q == COLLECT) && bus.in_valid_i && inReady;

    always_comb begin
        emitValid_d = 1'b0;
        emitData_d  = 32'h0;
        emitStrb_d  = 4'b0000;
        emitLast_d  = 1'b0;
`ifdef HYPER_READ_TIMEOUT_EN
        abort_d     = 1'b0;
`endif
        if (accept) begin
            if (pos_q) begin
                emitValid_d = 1'b1;
                emitData_d  = {bus.in_data_i, loVld_q ? accLo_q : 16'h0};
                emitStrb_d  = {2'b11, loVld_q, loVld_q};
                emitLast_d  = (rem_q == CNT_W'(1));
            end else if (rem_q == CNT_W'(1)) begin
                emitValid_d = 1'b1;
                emitData_d  = {16'h0, bus.in_data_i};
                emitStrb_d  = 4'b0011;
                emitLast_d  = 1'b1;
            end
        end
`ifdef HYPER_READ_TIMEOUT_EN
        // An abort flushes whatever low half is pending, but only once the output slot is free.
        else if ((state_q == COLLECT) && (cfg_timeout_i != '0) &&
                 (idleCnt_q >= cfg_timeout_i) && outFree) begin
            abort_d     = 1'b1;
            emitValid_d = 1'b1;
            emitData_d  = loVld_q ? {16'h0, accLo_q} : 32'h0;
            emitStrb_d  = loVld_q ? 4'b0011 : 4'b0000;
            emitLast_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk0 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            pos_q      <= 1'b0;
            loVld_q    <= 1'b0;
            accLo_q    <= 16'h0;
            outValid_q <= 1'b0;
            outData_q  <= 32'h0;
            outStrb_q  <= 4'b0000;
            outLast_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef HYPER_READ_TIMEOUT_EN
            idleCnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            if (outValid_q && bus.out_ready_i) begin
                outValid_q <= 1'b0;
            end
            if (emitValid_d) begin
                outValid_q <= 1'b1;
                outData_q  <= emitData_d;
                outStrb_q  <= emitStrb_d;
                outLast_q  <= emitLast_d;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
`ifdef HYPER_READ_TIMEOUT_EN
                        timeout_q <= 1'b0;
                        idleCnt_q <= '0;
`endif
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                            rem_q   <= len_i;
                            pos_q   <= half_offset_i;
                            loVld_q <= 1'b0;
                        end
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (!pos_q) begin
                            if (rem_q != CNT_W'(1)) begin
                                accLo_q <= bus.in_data_i;
                                loVld_q <= 1'b1;
                                pos_q   <= 1'b1;
                            end
                        end else begin
                            loVld_q <= 1'b0;
                            pos_q   <= 1'b0;
                        end
                    end
`ifdef HYPER_READ_TIMEOUT_EN
                    if (accept) begin
                        idleCnt_q <= '0;
                    end else if (idleCnt_q != '1) begin
                        idleCnt_q <= idleCnt_q + TO_W'(1);
                    end
                    if (abort_d) begin
                        timeout_q <= 1'b1;
                        loVld_q   <= 1'b0;
                    end
`endif
                    if (emitValid_d && emitLast_d) begin
                        state_q <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (outValid_q && bus.out_ready_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = inReady;
    assign bus.out_valid_o = outValid_q;
    assign bus.out_data_o  = outData_q;
    assign bus.out_strb_o  = outStrb_q;
    assign bus.out_last_o  = outLast_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
`ifdef HYPER_READ_TIMEOUT_EN
    assign timeout_o       = timeout_q;
`else
    assign timeout_o       = 1'b0;
`endif

endmodule

// File: doc/hyper_read_packer.md
# hyper_read_packer

Consumes the 16-bit halfword stream from the HyperBus read CDC FIFO in the `clk0` domain and packs it into 32-bit words with byte strobes and a last flag, ready for the AXI/register read-response path. It sits directly downstream of the RWDS-clocked read capture stage. Its `in_ready_o` drives that stage's FIFO `ready_i`. The controller FSM loads it once per read burst with a halfword count and a start offset.

## Interface
- `CNT_W`, 16: width of the halfword length counter.
- `TO_W`, 16: width of the timeout counter and `cfg_timeout_i`.

Ports:
- `clk0`  in  1: system clock; the only clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: one-cycle pulse that opens a read burst. Ignored unless the block is in IDLE.
- `len_i`  in  CNT_W: burst length in halfwords. Sampled on `start_i`.
- `half_offset_i`  in  1: the first halfword lands in bits [31:16]. Sampled on `start_i`.
- `cfg_timeout_i`  in  TO_W: inactivity limit in cycles; 0 disables the timeout.
- `in_valid_i`  in  1: halfword valid from the CDC FIFO.
- `in_data_i`  in  16: halfword data.
- `in_ready_o`  out  1: halfword accepted.
- `out_valid_o`  out  1: packed word valid.
- `out_data_o`  out  32: packed word.
- `out_strb_o`  out  4: byte strobes of the packed word.
- `out_last_o`  out  1: final word of the burst.
- `out_ready_i`  in  1: downstream accept.
- `busy_o`  out  1: burst in progress (state is not IDLE).
- `done_o`  out  1: one-cycle pulse when the burst closes.
- `timeout_o`  out  1: sticky burst-aborted flag; cleared by the next accepted `start_i`.

## Operation
States and transitions:
- **IDLE**
  - `in_ready_o`=1; halfwords arriving here are discarded.
  - `start_i` with `len_i`=0 → `done_o` pulses the next cycle; stays in IDLE.
  - `start_i` with `len_i`>0 → COLLECT. Loads `rem`=`len_i` and `pos`=`half_offset_i`, and clears `lo_vld`.
- **COLLECT**
  - `in_ready_o` = (!`out_valid_o` || `out_ready_i`).
  - A halfword is accepted on `in_valid_i && in_ready_o`; then `rem` decrements.
  - When `pos`=0 and `rem`>1: store the halfword in `acc_lo`, set `lo_vld`=1, set `pos`=1. No output.
  - When `pos`=0 and `rem`=1: emit {16'h0, data}, strb 4'b0011, last.
  - When `pos`=1: emit {data, `lo_vld` ? `acc_lo` : 16'h0}, strb {2'b11, `lo_vld`, `lo_vld`}. Set last if `rem`=1. Then clear `lo_vld` and set `pos`=0.
  - Emitting last → DRAIN.
- **DRAIN**
  - `in_ready_o`=0.
  - On `out_valid_o && out_ready_i` → IDLE, with a `done_o` pulse on the same edge.

Output register:
- Holds one word and stays stable while `out_valid_o && !out_ready_i`.
- Loading it while the previous word is being accepted in the same cycle is allowed; this gives full throughput.

Other rules:
- `start_i` while not in IDLE is ignored; none of `len_i`, `half_offset_i` or `timeout_o` change.
- A reset mid-burst returns to IDLE immediately and drops any partial word and the output register contents.
- Reset values: `out_valid_o`, `out_data_o`, `out_strb_o`, `out_last_o`, `busy_o`, `done_o` and `timeout_o` are all 0. `in_ready_o`=1, because IDLE is the reset state.

## Timing
- The accepting edge of the halfword that completes a word sets `out_valid_o` at that same edge. Visible latency is 1 cycle.
- Throughput: one halfword per cycle and one word every 2 cycles when `out_ready_i`=1 throughout.
- `done_o` is asserted in the cycle after the last word's handshake edge. It stays high for exactly one cycle.
- `busy_o` rises in the cycle after `start_i` and falls in the same cycle as `done_o`.

## Configuration
- `HYPER_READ_TIMEOUT_EN` defined:
  - In COLLECT, a counter increments on every cycle without a halfword accept. It resets on every accept.
  - When `cfg_timeout_i`≠0 and the counter reaches `cfg_timeout_i`, the burst is aborted and `timeout_o` is set.
  - Abort with `lo_vld`=1: emit {16'h0, `acc_lo`}, strb 4'b0011, last.
  - Abort with `lo_vld`=0: emit 32'h0, strb 4'b0000, last.
  - If the output register is still occupied, abort waits until it frees. After the abort word is emitted → DRAIN.
- Macro undefined:
  - No counter is built; `timeout_o` is tied to 0 and `cfg_timeout_i` is unused.
  - COLLECT waits for data indefinitely.

## Test plan
- `len_i`=4, offset 0, halfwords 0x1111, 0x2222, 0x3333, 0x4444, `out_ready_i`=1 → words 0x2222_1111/strb F and 0x4444_3333/strb F/last. `done_o` pulses one cycle after the second handshake.
- `len_i`=3, offset 1, halfwords 0x1111, 0x2222, 0x3333 → 0x1111_0000/strb C, then 0x3333_2222/strb F/last.
- `len_i`=1, halfword 0xAAAA → 0x0000_AAAA/strb 3/last. `len_i`=0 → `done_o` one cycle after `start_i`, no output beats.
- `len_i`=8, `out_ready_i` held low 5 cycles after the first word → `in_ready_o`=0 while the word is held, the word stays stable, and all 4 words arrive in order without loss.
- `HYPER_READ_TIMEOUT_EN` defined, `cfg_timeout_i`=8, `len_i`=4, a single halfword 0x5555 → after 8 idle cycles `timeout_o`=1, then 0x0000_5555/strb 3/last, then `done_o`. `timeout_o` clears on the next `start_i`.
- `rst_ni` asserted mid-burst after 3 halfwords → all outputs at reset values and `in_ready_o`=1. A fresh `len_i`=2 burst then produces a single clean word.
